// File: rtl/celery_pkg.sv
// Shared definitions for the UART response transmitter.
//   RESP_SYNC        sync byte that opens every response packet
//   RESP_ACK/STATUS/ERR  response opcodes
//   resp_t           one queued response request (opcode + payload)
//   tx_state_e       bit-level serializer states
//   resp_checksum()  XOR of the three bytes after the sync byte
package celery_pkg;

   localparam logic [7:0] RESP_SYNC   = 8'hA5;
   localparam logic [7:0] RESP_ACK    = 8'h01;
   localparam logic [7:0] RESP_STATUS = 8'h02;
   localparam logic [7:0] RESP_ERR    = 8'h03;

   localparam int PKT_BYTES = 5;

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] data;
   } resp_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   function automatic logic [7:0] resp_checksum(input resp_t r);
      return r.op ^ r.data[15:8] ^ r.data[7:0];
   endfunction

endpackage

// File: rtl/uart_tx.sv
// Bit-level UART serializer: 1 start bit, 8 data bits LSB first, 1 stop bit.
//   clk, rst_n  system clock, async active-low reset
//   data, valid byte offered by the packet sequencer
//   ready       byte is taken on this edge if valid is high (idle, or last
//               cycle of a stop bit so frames run back-to-back)
//   busy        a frame is on the line
//   tx          serial output, idle high, registered
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | line idle high, waiting for a byte
// ST_START | driving the start bit (0) for one bit time
// ST_DATA  | shifting out 8 data bits, LSB first
// ST_STOP  | driving the stop bit (1); may chain to ST_START
module uart_tx
   import celery_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       busy,
   output logic       tx
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             tx_q, tx_d;
   logic             bit_tc;

   // Down-counter reaches zero on the last cycle of the current bit.
   assign bit_tc = (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      ready   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (valid) begin
               state_d = ST_START;
               cnt_d   = CNT_LOAD;
               sh_d    = data;
               tx_d    = 1'b0;
            end
         end
         ST_START: begin
            if (bit_tc) begin
               state_d = ST_DATA;
               cnt_d   = CNT_LOAD;
               bit_d   = '0;
               tx_d    = sh_q[0];
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_DATA: begin
            if (bit_tc) begin
               cnt_d = CNT_LOAD;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  sh_d  = {1'b0, sh_q[7:1]};
                  tx_d  = sh_q[1];
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_STOP: begin
            if (bit_tc) begin
               // Accepting here keeps the next start bit flush with this stop bit.
               ready = 1'b1;
               if (valid) begin
                  state_d = ST_START;
                  cnt_d   = CNT_LOAD;
                  sh_d    = data;
                  tx_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign tx   = tx_q;

endmodule

// File: rtl/uart_resp_tx.sv
// Response packet transmitter: queues (op, data) requests in a FIFO and sends
// each as a 5-byte UART packet A5, op, data[15:8], data[7:0], checksum.
//   clk, rst_n             system clock, async active-low reset
//   resp_valid/resp_ready  request handshake; resp_ready = FIFO not full
//   resp_op, resp_data     request contents, captured on the transfer edge
//   tx                     UART serial output, idle high
//   tx_busy                packet in flight or FIFO non-empty
//
// A one-byte staging register sits between the packet sequencer and the
// serializer. It is refilled the cycle after the serializer takes a byte, so
// the next byte is always ready well before the current stop bit ends. The
// FIFO entry is popped and latched when byte 0 of its packet is staged.
module uart_resp_tx
   import celery_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        resp_valid,
   output logic        resp_ready,
   input  logic [7:0]  resp_op,
   input  logic [15:0] resp_data,
   output logic        tx,
   output logic        tx_busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   typedef logic [PTR_W:0] cnt_t;
   localparam cnt_t       FULL_CNT = cnt_t'(FIFO_DEPTH);
   localparam logic [2:0] LAST_IDX = 3'(PKT_BYTES - 1);

   resp_t            mem_q [FIFO_DEPTH];
   resp_t            mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   cnt_t             cnt_q, cnt_d;
   resp_t            cur_q, cur_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       stg_q, stg_d;
   logic             stg_vld_q, stg_vld_d;
   logic             rdy_en_q, rdy_en_d;

   logic fifo_empty, fifo_full;
   logic push, pop, load, take;
   logic utx_ready, utx_busy;

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == FULL_CNT);

   // rdy_en_q holds resp_ready low during reset and releases it on the first edge.
   assign resp_ready = rdy_en_q & ~fifo_full;
   assign push       = resp_valid & resp_ready;
   assign take       = stg_vld_q & utx_ready;
   assign load       = ~stg_vld_q & ((idx_q != 3'd0) | ~fifo_empty);
   assign pop        = load & (idx_q == 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         cur_q     <= '0;
         idx_q     <= '0;
         stg_q     <= '0;
         stg_vld_q <= 1'b0;
         rdy_en_q  <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         cur_q     <= cur_d;
         idx_q     <= idx_d;
         stg_q     <= stg_d;
         stg_vld_q <= stg_vld_d;
         rdy_en_q  <= rdy_en_d;
      end
   end

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cur_d     = cur_q;
      idx_d     = idx_q;
      stg_d     = stg_q;
      stg_vld_d = stg_vld_q;
      rdy_en_d  = 1'b1;

      if (push) begin
         mem_d[wr_ptr_q] = {resp_op, resp_data};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end

      if (pop) begin
         cur_d    = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);

      // load and take are exclusive: load needs the staging slot empty, take needs it full.
      if (load) begin
         stg_vld_d = 1'b1;
         idx_d     = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
         case (idx_q)
            3'd0:    stg_d = RESP_SYNC;
            3'd1:    stg_d = cur_q.op;
            3'd2:    stg_d = cur_q.data[15:8];
            3'd3:    stg_d = cur_q.data[7:0];
            default: stg_d = resp_checksum(cur_q);
         endcase
      end else if (take) begin
         stg_vld_d = 1'b0;
      end
   end

   uart_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) u_uart_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .data  (stg_q),
      .valid (stg_vld_q),
      .ready (utx_ready),
      .busy  (utx_busy),
      .tx    (tx)
   );

   assign tx_busy = utx_busy | ~fifo_empty | stg_vld_q | (idx_q != 3'd0);

endmodule

// File: tb/tb_uart_resp_tx.sv
// Directed bench for uart_resp_tx at 16 clocks per bit. Expected packet bytes
// are queued when a request is accepted; a mid-bit UART monitor pops and
// compares them as they arrive on tx.
module tb_uart_resp_tx;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        resp_valid = 1'b0;
   logic [7:0]  resp_op    = 8'h00;
   logic [15:0] resp_data  = 16'h0000;
   logic        resp_ready;
   logic        tx;
   logic        tx_busy;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         epoch = 0;
   int         acc_cyc = 0;
   logic [7:0] exp_q [$];

   logic [7:0]  bp_op   [6] = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03};
   logic [15:0] bp_data [6] = '{16'h0001, 16'h1020, 16'h00FF, 16'h8000, 16'h5555, 16'h0F0F};
   logic [7:0]  bp_cs   [6] = '{8'h00, 8'h32, 8'hFC, 8'h81, 8'h02, 8'h03};

   uart_resp_tx #(
      .CLK_FREQ   (16),
      .BAUD_RATE  (1),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_op    (resp_op),
      .resp_data  (resp_data),
      .tx         (tx),
      .tx_busy    (tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send(input logic [7:0] op, input logic [15:0] data,
                       input logic [7:0] csum, output int stalled);
      int guard;
      resp_valid = 1'b1;
      resp_op    = op;
      resp_data  = data;
      stalled    = 0;
      guard      = 0;
      while (resp_ready !== 1'b1 && guard < 3000) begin
         stalled = 1;
         guard++;
         @(negedge clk);
      end
      chk("send_ready_wait", guard < 3000, 1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      exp_q.push_back(8'hA5);
      exp_q.push_back(op);
      exp_q.push_back(data[15:8]);
      exp_q.push_back(data[7:0]);
      exp_q.push_back(csum);
      @(negedge clk);
   endtask

   task automatic wait_tx_fall(output int c);
      int g = 0;
      while (tx !== 1'b0 && g < 100) begin
         g++;
         @(negedge clk);
      end
      chk("tx_fall_wait", g < 100, 1);
      c = cyc;
   endtask

   task automatic wait_idle(output int c);
      int g = 0;
      while (tx_busy !== 1'b0 && g < 10000) begin
         g++;
         @(negedge clk);
      end
      chk("idle_wait", g < 10000, 1);
      c = cyc;
   endtask

   // UART monitor: samples every bit at its middle; bytes that straddle a
   // reset (epoch change) are discarded.
   initial begin
      logic [7:0] b;
      logic       s0;
      logic       e_bit;
      int         ep;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            ep = epoch;
            repeat (8) @(negedge clk);
            s0 = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (16) @(negedge clk);
               b[i] = tx;
            end
            repeat (16) @(negedge clk);
            e_bit = tx;
            if (ep == epoch) begin
               chk("rx_start_bit", s0, 0);
               chk("rx_stop_bit", e_bit, 1);
               chk("rx_byte_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  chk("rx_byte", b, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      int st;
      int first_stall;
      int first_acc;
      int fall_c;
      int busy_c;
      int zeros;

      // Reset values while rst_n is low.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_resp_ready", resp_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", resp_ready, 1);
      chk("busy_after_reset", tx_busy, 0);

      // Single request: A5 01 12 34 27, tx low 2 edges after accept, 800-cycle packet.
      send(8'h01, 16'h1234, 8'h27, st);
      resp_valid = 1'b0;
      wait_tx_fall(fall_c);
      chk("single_latency", fall_c - acc_cyc, 2);
      wait_idle(busy_c);
      chk("single_busy_len", busy_c - fall_c, 800);
      chk("single_drained", exp_q.size(), 0);

      // Checksum edge case: A5 FF FF 00 00.
      repeat (5) @(negedge clk);
      send(8'hFF, 16'hFF00, 8'h00, st);
      resp_valid = 1'b0;
      wait_idle(busy_c);
      chk("csum_drained", exp_q.size(), 0);

      // Backpressure: 6 back-to-back requests into a 4-deep FIFO. The first
      // entry is popped the cycle after its accept, so the 5th accept fills it.
      repeat (5) @(negedge clk);
      first_stall = -1;
      first_acc   = 0;
      for (int i = 0; i < 6; i++) begin
         send(bp_op[i], bp_data[i], bp_cs[i], st);
         if (i == 0) first_acc = acc_cyc;
         if (st != 0 && first_stall < 0) first_stall = i;
      end
      resp_valid = 1'b0;
      chk("bp_accepts_before_stall", first_stall, 5);
      wait_idle(busy_c);
      chk("bp_gapless_len", busy_c - first_acc, 2 + 6 * 800);
      chk("bp_drained", exp_q.size(), 0);

      // Mid-frame reset during data bit 3 of byte 2.
      repeat (5) @(negedge clk);
      send(8'h10, 16'hABCD, 8'h76, st);
      resp_valid = 1'b0;
      wait_tx_fall(fall_c);
      while (cyc < fall_c + 320 + 16 * 4 + 8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_tx", tx, 1);
      chk("midrst_tx_busy", tx_busy, 0);
      chk("midrst_resp_ready", resp_ready, 0);
      exp_q.delete();
      epoch++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready_rise", resp_ready, 1);
      zeros = 0;
      repeat (300) begin
         @(negedge clk);
         if (tx !== 1'b1) zeros++;
      end
      chk("midrst_no_residual", zeros, 0);
      chk("midrst_idle_busy", tx_busy, 0);
      send(8'h02, 16'h0000, 8'h02, st);
      resp_valid = 1'b0;
      wait_idle(busy_c);
      chk("midrst_drained", exp_q.size(), 0);

      // Input stability: inputs change right after the transfer edge.
      repeat (5) @(negedge clk);
      send(8'h03, 16'hC3A5, 8'h65, st);
      resp_valid = 1'b0;
      resp_op    = 8'h02;
      resp_data  = 16'h1111;
      wait_idle(busy_c);
      chk("stable_drained", exp_q.size(), 0);

      repeat (20) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_resp_tx.md
UART_RESP_TX -- requirements
Module: uart_resp_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, response entries buffered; power of two, at least 2.
REQ-004 clk  input  1  system clock; the block has one clock, all logic on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 resp_valid  input  1  response request present.
REQ-007 resp_ready  output  1  block can accept a request; a transfer occurs when resp_valid and resp_ready are both high on an edge.
REQ-008 resp_op  input  8  response opcode.
REQ-009 resp_data  input  16  response payload.
REQ-010 tx  output  1  UART serial output; idle high.
REQ-011 tx_busy  output  1  high while a packet is being serialized or the FIFO is non-empty.

Function
REQ-012 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD_RATE by integer division (434 at default); every bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 Byte frame: one start bit (0), 8 data bits LSB first, one stop bit (1); 10 bit times per byte.
REQ-014 Each accepted request SHALL produce a 5-byte packet in order: 0xA5, op, data[15:8], data[7:0], checksum.
REQ-015 Checksum = op XOR data[15:8] XOR data[7:0]; the 8-bit result excludes the sync byte.
REQ-016 Requests SHALL be stored in a FIFO of FIFO_DEPTH entries and transmitted in acceptance order; none are dropped or reordered.
REQ-017 resp_ready = not full; when the FIFO is full, resp_ready SHALL stay low even if a pop occurs in the same cycle.
REQ-018 Sequencer states: IDLE, START, DATA, STOP. IDLE->START when the FIFO is non-empty; START->DATA after 1 bit time; DATA->STOP after 8 bit times; STOP->START if packet bytes remain or the FIFO is non-empty, otherwise STOP->IDLE.
REQ-019 A FIFO entry SHALL be popped and latched when byte 0 of its packet is loaded; the byte index runs 0..4 and wraps to 0.
REQ-020 Latency: when the block is idle with an empty FIFO and a request is accepted at edge N, tx SHALL fall at edge N+2.
REQ-021 Consecutive bytes and consecutive packets SHALL be back-to-back with no idle bit time between a stop bit and the next start bit.
REQ-022 Simultaneous push and pop SHALL both take effect, so the FIFO count is unchanged.
REQ-023 resp_op and resp_data are sampled only on the transfer edge; later changes do not affect a queued packet.
REQ-024 tx_busy SHALL fall in the same cycle the sequencer enters IDLE with an empty FIFO.

Reset
REQ-025 When rst_n is low, all outputs SHALL take their reset values immediately: tx=1, tx_busy=0, resp_ready=0.
REQ-026 resp_ready SHALL rise on the first edge after reset is released.
REQ-027 A reset during any frame SHALL abandon the partial packet, empty the FIFO, and return the sequencer to IDLE with the bit counter and byte index at 0.

Structure
REQ-028 celery_pkg SHALL hold RESP_SYNC (8'hA5), the opcodes RESP_ACK (8'h01), RESP_STATUS (8'h02) and RESP_ERR (8'h03), and the struct resp_t {op[7:0], data[15:0]}.
REQ-029 The bit-level serializer SHALL be a separate sub-module, uart_tx (CLK_FREQ and BAUD_RATE parameters, data/valid/ready in, tx out); packet sequencing and the FIFO stay in uart_resp_tx.

Verification
REQ-030 The bench SHALL use CLK_FREQ=16 and BAUD_RATE=1 (16 cycles per bit) and a UART monitor sampling at mid-bit.
REQ-031 Single request: op=0x01, data=0x1234 -> bytes A5 01 12 34 27; tx falls 2 cycles after acceptance; tx_busy falls after exactly 800 cycles of serialization.
REQ-032 Backpressure: push 6 requests back-to-back with FIFO_DEPTH=4 -> resp_ready drops after the 4th accept (or 5th if a pop occurred), and all 6 packets arrive in order with no gaps.
REQ-033 Checksum edge case: op=0xFF, data=0xFF00 -> bytes A5 FF FF 00 00.
REQ-034 Mid-frame reset: assert rst_n low during bit 3 of byte 2 -> tx=1 immediately; after release, no residual bytes; a new request op=0x02, data=0x0000 -> A5 02 00 00 02.
REQ-035 Input stability: change resp_data on the cycle after a transfer -> the transmitted packet carries the value sampled at the transfer edge.
